// File: rtl/tlp_pkg.sv
// Shared constants, state encoding and credit helpers for the MWr32 transmitter.
package tlp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } tlp_state_e;

    localparam logic [7:0] FMT_TYPE_MWR32 = 8'h40;
    localparam logic [9:0] TLP_LEN_DW     = 10'd1;
    localparam logic [7:0] TLP_TAG        = 8'h00;
    localparam logic [3:0] FIRST_BE       = 4'hF;
    localparam logic [3:0] LAST_BE        = 4'h0;
    localparam int         HW_CNT         = 8;

    // Posted-header credit usable: infinite flag or a non-zero count.
    function automatic logic ph_credit_ok(input logic [8:0] ph);
        return ph[8] | (|ph[7:0]);
    endfunction

    // Posted-data credit usable: infinite flag or a non-zero count.
    function automatic logic pd_credit_ok(input logic [12:0] pd);
        return pd[12] | (|pd[11:0]);
    endfunction

endpackage

// File: rtl/tlp_mwr_tx_if.sv
// Transmit-side handshake between the MWr generator and the PCIe core.
interface tlp_mwr_tx_if;
    logic        tx_req;
    logic [15:0] tx_data;
    logic        tx_st;
    logic        tx_end;
    logic        tx_rdy;
    logic [8:0]  tx_ca_ph;
    logic [12:0] tx_ca_pd;

    modport master (
        output tx_req, tx_data, tx_st, tx_end,
        input  tx_rdy, tx_ca_ph, tx_ca_pd
    );

    modport slave (
        input  tx_req, tx_data, tx_st, tx_end,
        output tx_rdy, tx_ca_ph, tx_ca_pd
    );
endinterface

// File: rtl/sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc until every bit is set, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/tlp_mwr_tx.sv
// Turns each GPIO pattern event into a single-DW MWr32 TLP, streamed as
// eight big-endian halfwords. One event can wait in a holding buffer while
// a TLP is in flight; newer events overwrite it and are counted as drops.
//
// state | meaning
// IDLE  | no TLP in flight; waits for a held event, link up and credits
// REQ   | first cycle: arming tx_req; then tx_req high until tx_rdy seen
// DATA  | streaming halfwords H0..H7 from the latched payload
module tlp_mwr_tx
    import tlp_pkg::*;
#(
    parameter logic [31:0] ADDR  = 32'h0000_1000,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_valid,
    input  logic [31:0]      evt_data,
    input  logic             dl_up,
    input  logic [15:0]      req_id,
    tlp_mwr_tx_if.master     tx,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_DATA = ST_DATA;

    logic [1:0]  state;
    logic [2:0]  idx;
    logic        tx_req_q;
    logic        buf_full;
    logic [31:0] buf_data;
    logic [31:0] tlp_data;
    logic        grant;
    logic        start;
    logic        last_hw;
    logic        sent_inc;
    logic        drop_inc;
    logic [15:0] hw;

    // The buffer drains on the grant edge, so an event landing then is a capture, not a drop.
    assign grant    = (state == S_REQ) && tx_req_q && tx.tx_rdy;
    assign start    = buf_full && dl_up && ph_credit_ok(tx.tx_ca_ph) && pd_credit_ok(tx.tx_ca_pd);
    assign last_hw  = (state == S_DATA) && (idx == 3'(HW_CNT - 1));
    assign sent_inc = last_hw;
    assign drop_inc = evt_valid && buf_full && !grant;

    // Single-entry holding buffer; the newest event always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (evt_valid) begin
            buf_full <= 1'b1;
            buf_data <= evt_data;
        end else if (grant) begin
            buf_full <= 1'b0;
        end
    end

    // Request/stream sequencer; dl_up is only looked at before a TLP starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            tx_req_q <= 1'b0;
            tlp_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (start)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (grant) begin
                        state    <= S_DATA;
                        tx_req_q <= 1'b0;
                        idx      <= '0;
                        tlp_data <= buf_data;
                    end else begin
                        tx_req_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    idx <= idx + 1'b1;
                    if (last_hw)
                        state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    tx_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Halfword selection; bus is quiet outside DATA.
    always_comb begin
        hw = '0;
        if (state == S_DATA) begin
            case (idx)
                3'd0:    hw = {FMT_TYPE_MWR32, 8'h00};
                3'd1:    hw = {6'b0, TLP_LEN_DW};
                3'd2:    hw = req_id;
                3'd3:    hw = {TLP_TAG, LAST_BE, FIRST_BE};
                3'd4:    hw = ADDR[31:16];
                3'd5:    hw = {ADDR[15:2], 2'b00};
                3'd6:    hw = tlp_data[31:16];
                default: hw = tlp_data[15:0];
            endcase
        end
    end

    assign tx.tx_req  = tx_req_q;
    assign tx.tx_data = hw;
    assign tx.tx_st   = (state == S_DATA) && (idx == 3'd0);
    assign tx.tx_end  = last_hw;

    sat_cnt #(.W(CNT_W)) u_sent_cnt (
        .clk (clk),
        .rst (rst),
        .inc (sent_inc),
        .cnt (sent_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

endmodule

// File: tb/tb_tlp_mwr_tx.sv
// Directed bench for tlp_mwr_tx: TLP contents, buffering/drops, credit and
// grant stalls, async reset mid-TLP, and counter saturation on a narrow copy.
module tb_tlp_mwr_tx;
    localparam logic [15:0] REQ_ID = 16'hABCD;

    logic        clk;
    logic        rst;
    logic        evt_valid;
    logic [31:0] evt_data;
    logic        dl_up;
    logic [15:0] req_id;
    logic [15:0] sent_cnt;
    logic [15:0] drop_cnt;

    logic        evt_valid2;
    logic        dl_low;
    logic [1:0]  sent2;
    logic [1:0]  drop2;

    int errors = 0;
    int checks = 0;

    tlp_mwr_tx_if bus ();
    tlp_mwr_tx_if bus2 ();

    tlp_mwr_tx dut (
        .clk       (clk),
        .rst       (rst),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .dl_up     (dl_up),
        .req_id    (req_id),
        .tx        (bus),
        .sent_cnt  (sent_cnt),
        .drop_cnt  (drop_cnt)
    );

    tlp_mwr_tx #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .evt_valid (evt_valid2),
        .evt_data  (evt_data),
        .dl_up     (dl_low),
        .req_id    (req_id),
        .tx        (bus2),
        .sent_cnt  (sent2),
        .drop_cnt  (drop2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for tx_st, then checks all eight halfwords and strobes.
    // With inj set, event b is pulsed during H1 and event c during H2.
    task automatic check_tlp(input logic [31:0] d, input bit inj,
                             input logic [31:0] b, input logic [31:0] c,
                             output int waited);
        logic [15:0] exp_hw [8];
        exp_hw = '{16'h4000, 16'h0001, REQ_ID, 16'h000F,
                   16'h0000, 16'h1000, d[31:16], d[15:0]};
        waited = 0;
        while (bus.tx_st !== 1'b1 && waited < 40) begin
            tick();
            evt_valid = 1'b0;
            waited++;
        end
        chk("tlp_start_seen", bus.tx_st, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("hw%0d_data", i), bus.tx_data, exp_hw[i]);
            chk($sformatf("hw%0d_st", i), bus.tx_st, (i == 0));
            chk($sformatf("hw%0d_end", i), bus.tx_end, (i == 7));
            if (inj && i == 1) begin evt_valid = 1'b1; evt_data = b; end
            if (inj && i == 2) begin evt_valid = 1'b1; evt_data = c; end
            if (inj && i == 3) evt_valid = 1'b0;
            tick();
        end
        chk("post_tlp_data", bus.tx_data, 16'h0000);
        chk("post_tlp_end", bus.tx_end, 1'b0);
    endtask

    initial begin
        int w;
        bit ok;

        rst         = 1'b1;
        evt_valid   = 1'b0;
        evt_valid2  = 1'b0;
        evt_data    = '0;
        dl_up       = 1'b0;
        dl_low      = 1'b0;
        req_id      = REQ_ID;
        bus.tx_rdy  = 1'b1;
        bus.tx_ca_ph = 9'd1;
        bus.tx_ca_pd = 13'd1;
        bus2.tx_rdy  = 1'b1;
        bus2.tx_ca_ph = 9'd1;
        bus2.tx_ca_pd = 13'd1;

        tick();
        tick();
        chk("rst_tx_req", bus.tx_req, 1'b0);
        chk("rst_tx_st", bus.tx_st, 1'b0);
        chk("rst_tx_end", bus.tx_end, 1'b0);
        chk("rst_tx_data", bus.tx_data, 16'h0000);
        chk("rst_sent_cnt", sent_cnt, 16'h0000);
        chk("rst_drop_cnt", drop_cnt, 16'h0000);
        rst   = 1'b0;
        dl_up = 1'b1;
        tick();

        // Single event, 4-cycle latency, full TLP contents.
        evt_valid = 1'b1;
        evt_data  = 32'hFFFF_FFFE;
        tick();
        evt_valid = 1'b0;
        chk("lat_idle_no_req", bus.tx_req, 1'b0);
        tick();
        tick();
        chk("lat_req_high", bus.tx_req, 1'b1);
        chk("lat_no_st_yet", bus.tx_st, 1'b0);
        check_tlp(32'hFFFF_FFFE, 1'b0, '0, '0, w);
        chk("lat_4_cycles", w, 1);
        chk("single_sent_cnt", sent_cnt, 16'd1);
        chk("single_drop_cnt", drop_cnt, 16'd0);

        // Three events: first sent, second overwritten by third.
        evt_valid = 1'b1;
        evt_data  = 32'h1111_2222;
        tick();
        evt_valid = 1'b0;
        check_tlp(32'h1111_2222, 1'b1, 32'h3333_4444, 32'h5555_6666, w);
        chk("three_drop_cnt", drop_cnt, 16'd1);
        check_tlp(32'h5555_6666, 1'b0, '0, '0, w);
        chk("three_sent_cnt", sent_cnt, 16'd3);

        // Event arriving on the grant edge is captured without a drop.
        evt_valid = 1'b1;
        evt_data  = 32'hDEAD_0001;
        tick();
        evt_valid = 1'b0;
        w = 0;
        while (bus.tx_req !== 1'b1 && w < 20) begin tick(); w++; end
        chk("drain_req_seen", bus.tx_req, 1'b1);
        evt_valid = 1'b1;
        evt_data  = 32'hBEEF_0002;
        check_tlp(32'hDEAD_0001, 1'b0, '0, '0, w);
        chk("drain_no_drop", drop_cnt, 16'd1);
        check_tlp(32'hBEEF_0002, 1'b0, '0, '0, w);
        chk("drain_sent_cnt", sent_cnt, 16'd5);

        // No header credit: nothing requested until an infinite credit appears.
        bus.tx_ca_ph = 9'd0;
        evt_valid = 1'b1;
        evt_data  = 32'h0BAD_CAFE;
        tick();
        evt_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_req !== 1'b0 || bus.tx_st !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("credit_stall_no_req", ok, 1'b1);
        bus.tx_ca_ph = 9'h100;
        check_tlp(32'h0BAD_CAFE, 1'b0, '0, '0, w);
        chk("credit_sent_cnt", sent_cnt, 16'd6);
        bus.tx_ca_ph = 9'd1;

        // Grant withheld; dl_up dropping while requesting must not abort.
        bus.tx_rdy = 1'b0;
        evt_valid = 1'b1;
        evt_data  = 32'h1234_5678;
        tick();
        evt_valid = 1'b0;
        w = 0;
        while (bus.tx_req !== 1'b1 && w < 20) begin tick(); w++; end
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bus.tx_req !== 1'b1 || bus.tx_st !== 1'b0) ok = 1'b0;
            if (i == 4) dl_up = 1'b0;
            tick();
        end
        chk("grant_wait_req_held", ok, 1'b1);
        bus.tx_rdy = 1'b1;
        check_tlp(32'h1234_5678, 1'b0, '0, '0, w);
        chk("grant_sent_cnt", sent_cnt, 16'd7);
        dl_up = 1'b1;

        // Async reset at H3; no resumption afterwards.
        evt_valid = 1'b1;
        evt_data  = 32'hA5A5_5A5A;
        tick();
        evt_valid = 1'b0;
        w = 0;
        while (bus.tx_st !== 1'b1 && w < 20) begin tick(); w++; end
        tick();
        tick();
        tick();
        chk("rst_mid_h3", bus.tx_data, 16'h000F);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_data", bus.tx_data, 16'h0000);
        chk("rst_mid_end", bus.tx_end, 1'b0);
        chk("rst_mid_st", bus.tx_st, 1'b0);
        chk("rst_mid_req", bus.tx_req, 1'b0);
        chk("rst_mid_sent", sent_cnt, 16'd0);
        chk("rst_mid_drop", drop_cnt, 16'd0);
        tick();
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_req !== 1'b0 || bus.tx_st !== 1'b0 ||
                bus.tx_end !== 1'b0 || bus.tx_data !== 16'h0000) ok = 1'b0;
            tick();
        end
        chk("rst_no_resume", ok, 1'b1);

        // Saturation on the 2-bit copy with the link held down.
        for (int i = 0; i < 4; i++) begin
            evt_valid2 = 1'b1;
            evt_data   = 32'h100 + 32'(i);
            tick();
        end
        evt_valid2 = 1'b0;
        chk("sat_drop_at_max", drop2, 2'd3);
        chk("sat_link_down_no_req", bus2.tx_req, 1'b0);
        evt_valid2 = 1'b1;
        tick();
        evt_valid2 = 1'b0;
        tick();
        chk("sat_drop_stays", drop2, 2'd3);
        chk("sat_sent_zero", sent2, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tlp_mwr_tx.md
TLP_MWR_TX -- requirements
Module: tlp_mwr_tx

Interface
REQ-001 Parameter ADDR, default 32'h0000_1000, DW-aligned target address of every memory write; bits [1:0] SHALL be ignored.
REQ-002 Parameter CNT_W, default 16, width of the sent and dropped event counters.
REQ-003 clk  in  1  single clock domain (pcie_end_sys_clk_125); the block SHALL use one clock.
REQ-004 rst  in  1  asynchronous, active-high reset (~perstn).
REQ-005 evt_valid  in  1  one-cycle pulse: new GPIO pattern available.
REQ-006 evt_data  in  32  pattern value, valid with evt_valid.
REQ-007 dl_up  in  1  data link up; no TLP starts while low.
REQ-008 req_id  in  16  requester ID {bus_num, dev_num, func_num}.
REQ-009 tx_rdy  in  1  core grant for the requested TLP.
REQ-010 tx_ca_ph  in  9  posted-header credits; bit 8 = infinite.
REQ-011 tx_ca_pd  in  13  posted-data credits; bit 12 = infinite.
REQ-012 tx_req  out  1  TLP transmit request.
REQ-013 tx_data  out  16  TLP halfword, big-endian.
REQ-014 tx_st / tx_end  out  1 each  first / last halfword strobes.
REQ-015 sent_cnt / drop_cnt  out  CNT_W each  TLPs completed / events discarded.

Function
REQ-016 A 1-entry holding buffer SHALL capture evt_data on evt_valid when empty; evt_valid while full SHALL overwrite the held value and increment drop_cnt.
REQ-017 The FSM SHALL have states IDLE, REQ, DATA.
REQ-018 IDLE->REQ SHALL occur when the buffer is full, dl_up=1, ph credit ok (bit 8 set or [7:0]!=0) and pd credit ok (bit 12 set or [11:0]!=0); tx_req SHALL be asserted from the next cycle.
REQ-019 In REQ, tx_req SHALL remain high until tx_rdy is sampled high; tx_req SHALL drop in the cycle after tx_rdy is sampled, and the FSM SHALL enter DATA.
REQ-020 The payload SHALL be moved from the buffer into a TLP register on REQ->DATA; the buffer SHALL then be empty and may accept a new event in the same cycle.
REQ-021 DATA SHALL drive 8 halfwords on consecutive cycles, index 0..7, starting the cycle after tx_rdy is sampled: H0=16'h4000 (MWr32, length 1); H1=16'h0001; H2=req_id; H3=16'h000F (tag 0, lastBE 0, firstBE F); H4=ADDR[31:16]; H5={ADDR[15:2],2'b00}; H6=data[31:16]; H7=data[15:0].
REQ-022 tx_st SHALL be high only with H0, and tx_end only with H7; tx_data SHALL be 0 outside DATA.
REQ-023 After H7, the FSM SHALL return to IDLE and increment sent_cnt; a held event MAY start a new REQ on the following cycle.
REQ-024 dl_up falling in REQ or DATA SHALL NOT abort the TLP in flight.
REQ-025 An event arriving in the same cycle the buffer drains SHALL be captured, with no drop.
REQ-026 Both counters SHALL saturate at all-ones.
REQ-027 Latency from evt_valid (idle, credits ok, tx_rdy held high) to tx_st SHALL be 4 cycles.

Reset
REQ-028 On rst, the FSM SHALL enter IDLE, the buffer SHALL be empty, and tx_req, tx_st, tx_end, tx_data, sent_cnt and drop_cnt SHALL all be 0.
REQ-029 Reset asserted mid-TLP SHALL take effect immediately; no partial TLP SHALL resume after release.

Structure
REQ-030 Package tlp_pkg SHALL hold the FSM state enum, TLP fmt/type constant 8'h40, BE constants and halfword count 8.
REQ-031 A sub-module sat_cnt (saturating counter, width parameter) SHALL be instantiated twice.

Verification
REQ-032 Single event 32'hFFFF_FFFE, credits 1/1, tx_rdy high: exactly 8 halfwords 4000,0001,ID,000F,0000,1000,FFFF,FFFE; tx_st on H0; tx_end on H7; sent_cnt=1.
REQ-033 Three events during one TLP: first sent; second overwritten by third; drop_cnt=1; second TLP carries the third value.
REQ-034 tx_ca_ph=0 for 20 cycles, then 9'h100: tx_req stays low until the credit update, then the TLP is sent.
REQ-035 tx_rdy withheld for 10 cycles: tx_req held high throughout, no tx_st before the grant.
REQ-036 rst pulse at H3: all outputs 0 asynchronously; after release, no tx_end and no further halfwords without a new event.
REQ-037 drop_cnt forced to 16'hFFFF plus an extra drop: value stays at 16'hFFFF.
